ir_queue: RTL

- Parametrised multi-entry instruction register. Sits between the fetch stage and decode.
- Buffers up to DEPTH fetched instructions, each with its PC, in FIFO order with valid/ready handshakes on both sides.
- Presents the head entry fully field-decoded: opcode, funct3/7, register indices, and a format-selected immediate.
- Supports a single-cycle flush for branch redirect.

---
 rtl/ir_queue.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {instr, pc}
// whose head slot is decoded combinationally into RV32I fields and immediate.
package ir_queue_pkg;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
endpackage

module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output rv32i_opcode       opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       imm,
  output logic [CNT_W-1:0]  count
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push, pop;
  logic [31:0]      head_instr;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  // A pop this cycle frees a slot, so a full queue may still accept.
  assign in_ready  = ~full | out_ready;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q] <= in_instr;
      pc_mem[wptr_q]    <= in_pc;
    end
  end

  assign head_instr = out_valid ? instr_mem[rptr_q] : NOP;
  assign out_instr  = head_instr;
  assign out_pc     = out_valid ? pc_mem[rptr_q] : '0;

  assign opcode = rv32i_opcode'(head_instr[6:0]);
  assign funct3 = head_instr[14:12];
  assign funct7 = head_instr[31:25];
  assign rs1    = head_instr[19:15];
  assign rs2    = head_instr[24:20];
  assign rd     = head_instr[11:7];

  always_comb begin
    imm = '0;
    case (opcode)
      op_imm, op_load, op_jalr:
        imm = {{20{head_instr[31]}}, head_instr[31:20]};
      op_store:
        imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      op_br:
        imm = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
               head_instr[30:25], head_instr[11:8], 1'b0};
      op_lui, op_auipc:
        imm = {head_instr[31:12], 12'h000};
      op_jal:
        imm = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
               head_instr[20], head_instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  // Fetch must hold a stalled instruction steady until it is accepted.
  a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> ($stable(in_instr) && $stable(in_pc)));

endmodule
